// File: rtl/ysyx_23060061_inst_enc.sv
// ysyx_23060061_inst_enc: RV32I field packer with range/alignment checks and li -> LUI+ADDI expansion,
// delivered through a one-entry registered valid/ready output.
module ysyx_23060061_inst_enc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_type,
    input  logic        in_li,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic        in_funct7_en,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [1:0]  out_err,
    output logic        out_last
);
    typedef enum logic {IDLE, HI_SENT} state_t;
    state_t      state, state_d;
    logic [31:0] imm, word, li_inst, enc_inst, pend, addi_lo;
    logic [19:0] hi;
    logic [1:0]  enc_err;
    logic        accept, drain, fit12, fit13, fit21, rng, mis, bad, two;

    assign imm      = in_imm;
    assign in_ready = (state == IDLE) & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;
    assign fit12    = &imm[31:11] | ~|imm[31:11];
    assign fit13    = &imm[31:12] | ~|imm[31:12];
    assign fit21    = &imm[31:20] | ~|imm[31:20];
    assign bad      = in_type > 3'd4;
    // rounding the upper part up whenever the low half will be sign-extended negative
    assign hi       = imm[31:12] + {19'd0, imm[11]};
    assign addi_lo  = {imm[11:0], in_rd, 3'b000, in_rd, 7'b0010011};
    assign li_inst  = fit12 ? {imm[11:0], 5'd0, 3'b000, in_rd, 7'b0010011} : {hi, in_rd, 7'b0110111};
    assign two      = in_li & ~fit12 & |imm[11:0];

    always_comb begin
        word = '0;
        rng  = 1'b0;
        mis  = 1'b0;
        case (in_type)
            3'd0: begin
                word = in_funct7_en ? {in_funct7, imm[4:0], in_rs1, in_funct3, in_rd, in_opcode}
                                    : {imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                rng  = in_funct7_en ? |imm[31:5] : ~fit12;
            end
            3'd1: begin
                word = {imm[11:5], in_rs2, in_rs1, in_funct3, imm[4:0], in_opcode};
                rng  = ~fit12;
            end
            3'd2: begin
                word = {imm[12], imm[10:5], in_rs2, in_rs1, in_funct3, imm[4:1], imm[11], in_opcode};
                mis  = imm[0];
                rng  = ~fit13;
            end
            3'd3: begin
                word = {imm[31:12], in_rd, in_opcode};
                mis  = |imm[11:0];
            end
            3'd4: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], in_rd, in_opcode};
                mis  = imm[0];
                rng  = ~fit21;
            end
            default: ;
        endcase
    end

    assign enc_inst = in_li ? li_inst : word;
    assign enc_err  = in_li ? 2'b00 : bad ? 2'b11 : mis ? 2'b10 : rng ? 2'b01 : 2'b00;

    always_comb begin
        state_d = state;
        if (accept & two)
            state_d = HI_SENT;
        else if (state == HI_SENT & drain)
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_err   <= 2'b00;
            out_last  <= 1'b0;
            pend      <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_inst  <= enc_inst;
            out_err   <= enc_err;
            out_last  <= ~two;
            pend      <= addi_lo;
        end else if (drain & state == HI_SENT) begin
            out_inst  <= pend;
            out_err   <= 2'b00;
            out_last  <= 1'b1;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ysyx_23060061_inst_enc.sv
// tb_ysyx_23060061_inst_enc: directed and random stimulus against a queue-based reference model,
// with an ImmGen-style decoder closing the round trip on error-free words.
module tb_ysyx_23060061_inst_enc;
    logic        clk = 0, rst_n = 0, in_valid = 0, in_li = 0, in_funct7_en = 0, out_ready = 0;
    logic [2:0]  in_type = 0, in_funct3 = 0;
    logic [6:0]  in_opcode = 0, in_funct7 = 0;
    logic [4:0]  in_rd = 0, in_rs1 = 0, in_rs2 = 0;
    logic [31:0] in_imm = 0;
    logic        in_ready, out_valid, out_last;
    logic [31:0] out_inst;
    logic [1:0]  out_err;

    ysyx_23060061_inst_enc dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
        .in_li(in_li), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_funct7_en(in_funct7_en), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_err(out_err), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [1:0]  err;
        logic        last;
        logic        rt;
        logic [2:0]  typ;
        logic [31:0] imm;
    } exp_t;

    exp_t q[$];
    int   checks = 0, passed = 0;
    bit   chk_on = 0, rnd_ready = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] sx(logic [31:0] v, int b);
        logic [31:0] t;
        t = v << (32 - b);
        return $signed(t) >>> (32 - b);
    endfunction

    function automatic logic in_range(logic [31:0] v, int b);
        int s, lim;
        s = $signed(v);
        lim = 1 << (b - 1);
        return s >= -lim && s < lim;
    endfunction

    function automatic logic [31:0] decode(logic [31:0] i, logic [2:0] t);
        case (t)
            3'd0: return sx({20'd0, i[31:20]}, 12);
            3'd1: return sx({20'd0, i[31:25], i[11:7]}, 12);
            3'd2: return sx({19'd0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
            3'd3: return {i[31:12], 12'd0};
            default: return sx({11'd0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
        endcase
    endfunction

    task automatic push(logic [31:0] i, logic [1:0] e, logic l, logic r, logic [2:0] t, logic [31:0] m);
        q.push_back('{inst: i, err: e, last: l, rt: r, typ: t, imm: m});
    endtask

    task automatic model_push();
        logic [31:0] im, op, f3, rd, rs1, rs2, f7, w;
        logic al, rg;
        int s;
        im = in_imm; op = 32'(in_opcode); f3 = 32'(in_funct3); rd = 32'(in_rd);
        rs1 = 32'(in_rs1); rs2 = 32'(in_rs2); f7 = 32'(in_funct7); s = $signed(in_imm);
        al = 0; rg = 0; w = 0;
        if (in_li) begin
            if (s >= -2048 && s <= 2047)
                push((im & 32'hFFF) << 20 | rd << 7 | 32'h13, 2'd0, 1'b1, 1'b0, 3'd0, im);
            else if ((im & 32'hFFF) == 0)
                push(im | rd << 7 | 32'h37, 2'd0, 1'b1, 1'b0, 3'd0, im);
            else begin
                push(((im + 32'h800) & 32'hFFFFF000) | rd << 7 | 32'h37, 2'd0, 1'b0, 1'b0, 3'd0, im);
                push((im & 32'hFFF) << 20 | rd << 15 | rd << 7 | 32'h13, 2'd0, 1'b1, 1'b0, 3'd0, im);
            end
        end else if (in_type > 3'd4) begin
            push(32'd0, 2'd3, 1'b1, 1'b0, in_type, im);
        end else begin
            case (in_type)
                3'd0: if (in_funct7_en) begin
                    w = f7 << 25 | (im & 31) << 20 | rs1 << 15 | f3 << 12 | rd << 7 | op;
                    rg = im > 31;
                end else begin
                    w = (im & 32'hFFF) << 20 | rs1 << 15 | f3 << 12 | rd << 7 | op;
                    rg = !in_range(im, 12);
                end
                3'd1: begin
                    w = ((im >> 5) & 127) << 25 | rs2 << 20 | rs1 << 15 | f3 << 12 | (im & 31) << 7 | op;
                    rg = !in_range(im, 12);
                end
                3'd2: begin
                    w = ((im >> 12) & 1) << 31 | ((im >> 5) & 63) << 25 | rs2 << 20 | rs1 << 15 | f3 << 12
                      | ((im >> 1) & 15) << 8 | ((im >> 11) & 1) << 7 | op;
                    al = (im & 1) != 0;
                    rg = !in_range(im, 13);
                end
                3'd3: begin
                    w = (im & 32'hFFFFF000) | rd << 7 | op;
                    al = (im & 32'hFFF) != 0;
                end
                default: begin
                    w = ((im >> 20) & 1) << 31 | ((im >> 1) & 1023) << 21 | ((im >> 11) & 1) << 20
                      | ((im >> 12) & 255) << 12 | rd << 7 | op;
                    al = (im & 1) != 0;
                    rg = !in_range(im, 21);
                end
            endcase
            push(w, al ? 2'd2 : rg ? 2'd1 : 2'd0, 1'b1, !in_funct7_en, in_type, im);
        end
    endtask

    // Per-cycle comparison of the DUT against the model queue, then advance the model.
    always @(negedge clk) begin
        exp_t e;
        if (chk_on) begin
            check("out_valid", 32'(out_valid), 32'(q.size() != 0));
            check("in_ready", 32'(in_ready), 32'(q.size() == 0 || (q.size() == 1 && out_ready)));
            if (q.size() != 0 && out_valid) begin
                check("model_inst", out_inst, q[0].inst);
                check("model_err", 32'(out_err), 32'(q[0].err));
                check("model_last", 32'(out_last), 32'(q[0].last));
            end
            if (!rst_n) q.delete();
            else begin
                if (out_valid && out_ready && q.size() != 0) begin
                    e = q.pop_front();
                    if (e.rt && e.err == 2'd0) check("roundtrip", decode(out_inst, e.typ), e.imm);
                end
                if (in_valid && in_ready) model_push();
            end
        end
    end

    always @(posedge clk) if (rnd_ready) #1 out_ready = 1'($urandom_range(0, 1));

    task automatic req(logic [2:0] t, logic li, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                       logic f7en, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm);
        int n;
        in_type = t; in_li = li; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_funct7_en = f7en; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (n == 50) check("req_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic drain1();
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
    endtask

    task automatic expect_word(string name, logic [31:0] inst, logic [1:0] err, logic last);
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_inst"}, out_inst, inst);
        check({name, "_err"}, 32'(out_err), 32'(err));
        check({name, "_last"}, 32'(out_last), 32'(last));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, imm;
        logic [2:0]  t;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk_on = 1;
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_inst", out_inst, 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        req(3'd0, 1'b0, 7'h13, 3'd0, 7'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);
        expect_word("i_addi", 32'hFFF00093, 2'b00, 1'b1);
        drain1();

        req(3'd0, 1'b1, 7'h00, 3'd0, 7'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345678);
        expect_word("li_hi", 32'h123452B7, 2'b00, 1'b0);
        check("li_busy", 32'(in_ready), 32'd0);
        drain1();
        expect_word("li_lo", 32'h67828293, 2'b00, 1'b1);
        drain1();
        req(3'd0, 1'b1, 7'h00, 3'd0, 7'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h00000800);
        expect_word("li800_hi", 32'h000012B7, 2'b00, 1'b0);
        drain1();
        expect_word("li800_lo", 32'h80028293, 2'b00, 1'b1);
        drain1();
        req(3'd0, 1'b1, 7'h00, 3'd0, 7'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'hFFFFFFFB);
        expect_word("li_small", 32'hFFB00193, 2'b00, 1'b1);
        drain1();
        req(3'd0, 1'b1, 7'h00, 3'd0, 7'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'h12345000);
        expect_word("li_lui", 32'h123451B7, 2'b00, 1'b1);
        drain1();

        req(3'd2, 1'b0, 7'h63, 3'd0, 7'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        expect_word("b_ok", 32'h00208463, 2'b00, 1'b1);
        drain1();
        req(3'd2, 1'b0, 7'h63, 3'd0, 7'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7);
        @(negedge clk) check("b_align", 32'(out_err), 32'd2);
        drain1();
        req(3'd2, 1'b0, 7'h63, 3'd0, 7'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'h00001000);
        @(negedge clk) check("b_range", 32'(out_err), 32'd1);
        drain1();
        req(3'd5, 1'b0, 7'h63, 3'd0, 7'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        expect_word("badtype", 32'h00000000, 2'b11, 1'b1);
        drain1();

        req(3'd0, 1'b0, 7'h13, 3'd0, 7'd0, 1'b0, 5'd2, 5'd1, 5'd0, 32'd100);
        for (int i = 0; i < 3; i++) begin
            expect_word("bp_hold", 32'h06408113, 2'b00, 1'b1);
            check("bp_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            in_type = 3'd0; in_li = 0; in_funct7_en = 0; in_opcode = 7'h13;
            in_rd = 5'(i); in_rs1 = 5'(i + 1); in_imm = 32'(i * 3); in_valid = 1;
            @(negedge clk) check("b2b_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk) check("b2b_empty", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        out_ready = 1;
        req(3'd0, 1'b1, 7'h00, 3'd0, 7'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345678);
        @(posedge clk);
        #1 rst_n = 0; out_ready = 0;
        @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rmid_valid", 32'(out_valid), 32'd0);
            check("rmid_ready", 32'(in_ready), 32'd1);
        end
        check("rmid_inst", out_inst, 32'd0);

        rnd_ready = 1;
        for (int i = 0; i < 80; i++) begin
            r = $urandom;
            t = 3'($urandom_range(0, 4));
            case (t)
                3'd0, 3'd1: imm = sx(r, 12);
                3'd2: imm = sx(r & ~32'd1, 13);
                3'd3: imm = r & 32'hFFFFF000;
                default: imm = sx(r & ~32'd1, 21);
            endcase
            if (i % 8 == 7) imm = $urandom;
            if (i % 5 == 4)
                req(t, 1'b1, 7'h00, 3'd0, 7'd0, 1'b0, 5'($urandom), 5'd0, 5'd0, (i % 10 == 4) ? $urandom : imm);
            else if (t == 3'd0 && i % 6 == 1)
                req(t, 1'b0, 7'h13, 3'd5, (i % 12 == 1) ? 7'h20 : 7'h00, 1'b1, 5'($urandom), 5'($urandom), 5'd0, r & 32'h3F);
            else
                req(t, 1'b0, 7'($urandom), 3'($urandom), 7'd0, 1'b0, 5'($urandom), 5'($urandom), 5'($urandom), imm);
        end
        rnd_ready = 0;
        @(posedge clk);
        #1 out_ready = 1;
        repeat (4) @(posedge clk);
        @(negedge clk) check("final_drained", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
